router_input_buffer: RTL and testbench

//  Router ingress port: accepts link flits tagged with a VC id, stores them in per-VC FIFOs,

---
 rtl/router_input_buffer.sv | 242 ++++++++++++++++++++++++
 tb/tb_router_input_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : router_input_buffer
// Purpose  : Router ingress port. Stores link flits in per-VC circular FIFOs,
//            computes the XY route of head flits, holds that route per VC for
//            the rest of the packet, and presents the head of the
//            highest-priority non-empty VC (VC0 first) with a one-hot route.
// Options  : ROUTER_IB_ERR_CHK_EN - when defined, malformed flits reaching a
//            FIFO head are dropped silently and a sticky err_o is raised.
// Revision : 1.0 - initial release
// ============================================================================
module router_input_buffer #(
    parameter int FLIT_WIDTH = 34,
    parameter int N_VC       = 3,
    parameter int VC_WIDTH   = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int X_ID       = 0,
    parameter int Y_ID       = 0
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  fin_valid_i,
    input  logic [VC_WIDTH-1:0]   fin_vc_i,
    input  logic [FLIT_WIDTH-1:0] fin_flit_i,
    output logic                  fin_ready_o,
    output logic                  fout_valid_o,
    output logic [VC_WIDTH-1:0]   fout_vc_o,
    output logic [FLIT_WIDTH-1:0] fout_flit_o,
    output logic [4:0]            fout_route_o,
    input  logic                  fout_ready_i,
    output logic                  err_o
);

    localparam int c_ADDR_W = $clog2(BUF_DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_PKT  = 1'b1;

    localparam logic [1:0] c_T_HEAD = 2'd0;
    localparam logic [1:0] c_T_BODY = 2'd1;
    localparam logic [1:0] c_T_TAIL = 2'd2;
    localparam logic [1:0] c_T_RSVD = 2'd3;

    localparam logic [4:0] c_RT_L = 5'b00001;
    localparam logic [4:0] c_RT_N = 5'b00010;
    localparam logic [4:0] c_RT_S = 5'b00100;
    localparam logic [4:0] c_RT_W = 5'b01000;
    localparam logic [4:0] c_RT_E = 5'b10000;

    logic [N_VC-1:0]       w_full;
    logic [N_VC-1:0]       w_empty;
    logic [N_VC-1:0]       w_pop_vec;
    logic [FLIT_WIDTH-1:0] w_head_flit [N_VC];
    logic [4:0]            w_route_vc  [N_VC];

    logic                  w_push;
    logic                  w_pop;
    logic                  w_any;
    logic                  w_valid;
    logic                  w_malformed;
    logic [VC_WIDTH-1:0]   w_sel_vc;
    logic [FLIT_WIDTH-1:0] w_sel_flit;
    logic [4:0]            w_sel_route_reg;
    logic [4:0]            w_xy_route;
    logic [4:0]            w_sel_route;
    logic [1:0]            w_sel_type;
    logic                  w_sel_dst_x;
    logic                  w_sel_dst_y;
    logic [7:0]            w_sel_size;

`ifdef ROUTER_IB_ERR_CHK_EN
    logic [N_VC-1:0]       w_state_vc;
    logic                  w_sel_pkt;
    logic                  r_err;
`endif

    assign w_sel_type  = w_sel_flit[FLIT_WIDTH-1 -: 2];
    assign w_sel_dst_x = w_sel_flit[FLIT_WIDTH-3];
    assign w_sel_dst_y = w_sel_flit[FLIT_WIDTH-4];
    assign w_sel_size  = w_sel_flit[FLIT_WIDTH-5 -: 8];

    // Ingress ready reflects only the addressed VC; out-of-range VC ids are refused.
    always_comb begin
        fin_ready_o = 1'b0;
        for (int v = 0; v < N_VC; v++) begin
            if (fin_vc_i == VC_WIDTH'(v)) begin
                fin_ready_o = ~w_full[v];
            end
        end
    end

    assign w_push = fin_valid_i && fin_ready_o;

    for (genvar gv = 0; gv < N_VC; gv++) begin : g_vc
        logic [FLIT_WIDTH-1:0] r_mem [BUF_DEPTH];
        logic [c_PTR_W-1:0]    r_wr_ptr;
        logic [c_PTR_W-1:0]    r_rd_ptr;
        logic [0:0]            r_state;
        logic [4:0]            r_route;
        logic                  w_push_vc;

        assign w_push_vc       = w_push && (fin_vc_i == VC_WIDTH'(gv));
        assign w_empty[gv]     = (r_wr_ptr == r_rd_ptr);
        assign w_full[gv]      = (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]) &&
                                 (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]);
        assign w_head_flit[gv] = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
        assign w_route_vc[gv]  = r_route;
        assign w_pop_vec[gv]   = w_pop && (w_sel_vc == VC_WIDTH'(gv));
`ifdef ROUTER_IB_ERR_CHK_EN
        assign w_state_vc[gv]  = (r_state == c_ST_PKT);
`endif

        // Flit storage; contents need no reset because the pointers gate visibility.
        always_ff @(posedge clk) begin
            if (w_push_vc) begin
                r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= fin_flit_i;
            end
        end

        // Read/write pointers with an extra wrap bit to tell full from empty.
        always_ff @(posedge clk) begin
            if (arst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_vc) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop_vec[gv]) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end

        // Packet FSM and route hold; only advances when a forwarded flit is popped.
        always_ff @(posedge clk) begin
            if (arst) begin
                r_state <= c_ST_IDLE;
                r_route <= '0;
            end else if (w_pop_vec[gv] && w_valid) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_sel_type == c_T_HEAD && w_sel_size != 8'd0) begin
                            r_state <= c_ST_PKT;
                            r_route <= w_xy_route;
                        end
                    end
                    default: begin
                        // A head seen mid-packet restarts the packet.
                        if (w_sel_type == c_T_HEAD) begin
                            if (w_sel_size != 8'd0) begin
                                r_route <= w_xy_route;
                            end else begin
                                r_state <= c_ST_IDLE;
                            end
                        end else if (w_sel_type == c_T_TAIL) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Fixed priority: the lowest-index non-empty VC wins (scan high to low, last hit sticks).
    always_comb begin
        w_any           = 1'b0;
        w_sel_vc        = '0;
        w_sel_flit      = '0;
        w_sel_route_reg = '0;
        for (int v = N_VC - 1; v >= 0; v--) begin
            if (!w_empty[v]) begin
                w_any           = 1'b1;
                w_sel_vc        = VC_WIDTH'(v);
                w_sel_flit      = w_head_flit[v];
                w_sel_route_reg = w_route_vc[v];
            end
        end
    end

    // Dimension-ordered XY route: resolve X first, then Y, otherwise local.
    always_comb begin
        w_xy_route = c_RT_L;
        if (int'(w_sel_dst_x) > X_ID) begin
            w_xy_route = c_RT_E;
        end else if (int'(w_sel_dst_x) < X_ID) begin
            w_xy_route = c_RT_W;
        end else if (int'(w_sel_dst_y) > Y_ID) begin
            w_xy_route = c_RT_S;
        end else if (int'(w_sel_dst_y) < Y_ID) begin
            w_xy_route = c_RT_N;
        end
    end

    assign w_sel_route = (w_sel_type == c_T_HEAD) ? w_xy_route : w_sel_route_reg;

`ifdef ROUTER_IB_ERR_CHK_EN
    // Packet state of the currently selected VC.
    always_comb begin
        w_sel_pkt = 1'b0;
        for (int v = N_VC - 1; v >= 0; v--) begin
            if (!w_empty[v]) begin
                w_sel_pkt = w_state_vc[v];
            end
        end
    end

    assign w_malformed = w_any && ((w_sel_type == c_T_RSVD) ||
                                   (w_sel_type == c_T_HEAD && w_sel_pkt) ||
                                   ((w_sel_type == c_T_BODY || w_sel_type == c_T_TAIL) && !w_sel_pkt));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (arst) begin
            r_err <= 1'b0;
        end else if (w_malformed) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign w_malformed = 1'b0;
    assign err_o       = 1'b0;
`endif

    // Malformed flits leave the FIFO without a handshake and are never presented.
    assign w_valid = w_any && !w_malformed;
    assign w_pop   = (w_valid && fout_ready_i) || w_malformed;

    // Output lane is all-zero whenever nothing is being presented.
    always_comb begin
        fout_valid_o = w_valid;
        fout_vc_o    = '0;
        fout_flit_o  = '0;
        fout_route_o = '0;
        if (w_valid) begin
            fout_vc_o    = w_sel_vc;
            fout_flit_o  = w_sel_flit;
            fout_route_o = w_sel_route;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_input_buffer
// Purpose  : Self-checking bench for router_input_buffer (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_input_buffer;

    localparam int FW  = 34;
    localparam int NVC = 3;
    localparam int VW  = 2;

    localparam logic [1:0] HD = 2'd0;
    localparam logic [1:0] BD = 2'd1;
    localparam logic [1:0] TL = 2'd2;

    localparam logic [4:0] RL = 5'b00001;
    localparam logic [4:0] RS = 5'b00100;
    localparam logic [4:0] RE = 5'b10000;

`ifdef ROUTER_IB_ERR_CHK_EN
    localparam bit ERR_CHK = 1'b1;
`else
    localparam bit ERR_CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          fin_valid_i = 1'b0;
    logic [VW-1:0] fin_vc_i = '0;
    logic [FW-1:0] fin_flit_i = '0;
    logic          fin_ready_o;
    logic          fout_valid_o;
    logic [VW-1:0] fout_vc_o;
    logic [FW-1:0] fout_flit_o;
    logic [4:0]    fout_route_o;
    logic          fout_ready_i = 1'b0;
    logic          err_o;

    always #5 clk = ~clk;

    router_input_buffer dut (
        .clk          (clk),
        .arst         (arst),
        .fin_valid_i  (fin_valid_i),
        .fin_vc_i     (fin_vc_i),
        .fin_flit_i   (fin_flit_i),
        .fin_ready_o  (fin_ready_o),
        .fout_valid_o (fout_valid_o),
        .fout_vc_o    (fout_vc_o),
        .fout_flit_o  (fout_flit_o),
        .fout_route_o (fout_route_o),
        .fout_ready_i (fout_ready_i),
        .err_o        (err_o)
    );

    typedef struct {
        logic [FW-1:0] flit;
        logic [4:0]    route;
    } exp_t;

    typedef struct {
        int          vc;
        bit          dx;
        bit          dy;
        logic [21:0] data;
        logic [4:0]  exp_route;
    } vec_t;

    exp_t sb_q [NVC][$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    bit   mon_en = 1'b0;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input bit dx, input bit dy,
                                         input logic [7:0] sz, input logic [21:0] d);
        return {t, dx, dy, sz, d};
    endfunction

    function automatic int total();
        int t = 0;
        for (int v = 0; v < NVC; v++) t += sb_q[v].size();
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: the presented flit must be the front of the lowest non-empty VC queue.
    always @(negedge clk) begin : mon
        int   ev;
        exp_t e;
        if (mon_en && fout_valid_o) begin
            ev = -1;
            for (int v = NVC - 1; v >= 0; v--) if (sb_q[v].size() > 0) ev = v;
            if (ev < 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got vc %0d flit %0h, expected no output", fout_vc_o, fout_flit_o);
            end else begin
                e = sb_q[ev][0];
                chk("out_vc", 64'(fout_vc_o), 64'(ev));
                chk("out_flit", 64'(fout_flit_o), 64'(e.flit));
                chk("out_route", 64'(fout_route_o), 64'(e.route));
                if (fout_ready_i) begin
                    void'(sb_q[ev].pop_front());
                    popped++;
                end
            end
        end
    end

    // Drive one flit at posedge+1; expectation is queued only once the push edge has passed.
    task automatic push(input int vc, input logic [FW-1:0] f, input logic [4:0] rt,
                        input bit expect_out, output bit acc);
        exp_t e;
        fin_valid_i = 1'b1;
        fin_vc_i    = vc[VW-1:0];
        fin_flit_i  = f;
        @(negedge clk);
        acc = fin_ready_o;
        @(posedge clk);
        if (acc && expect_out) begin
            e.flit  = f;
            e.route = rt;
            sb_q[vc].push_back(e);
        end
        #1 fin_valid_i = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        int tot;
        fout_ready_i = 1'b1;
        tot = total();
        while (tot > 0 && n < budget) begin
            @(posedge clk);
            n++;
            tot = total();
        end
        #1 fout_ready_i = 1'b0;
        chk({nm, "_left"}, 64'(tot), 64'd0);
        @(negedge clk);
        chk({nm, "_idle"}, 64'(fout_valid_o), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fout_ready_i = 1'b0;
        mon_en = 1'b0;
        arst = 1'b1;
        for (int v = 0; v < NVC; v++) sb_q[v].delete();
        @(posedge clk);
        #1 arst = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        bit            acc;
        int            p0;
        logic [FW-1:0] f;
        vec_t          tbl [6];

        tbl[0] = '{vc: 1, dx: 1'b0, dy: 1'b0, data: 22'h000A1, exp_route: RL};
        tbl[1] = '{vc: 0, dx: 1'b1, dy: 1'b0, data: 22'h3FFFF, exp_route: RE};
        tbl[2] = '{vc: 2, dx: 1'b0, dy: 1'b1, data: 22'h12345, exp_route: RS};
        tbl[3] = '{vc: 0, dx: 1'b1, dy: 1'b1, data: 22'h00000, exp_route: RE};
        tbl[4] = '{vc: 2, dx: 1'b0, dy: 1'b0, data: 22'h2AAAA, exp_route: RL};
        tbl[5] = '{vc: 1, dx: 1'b1, dy: 1'b0, data: 22'h15555, exp_route: RE};

        // Reset state
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(fout_valid_o), 64'd0);
        chk("rst_vc", 64'(fout_vc_o), 64'd0);
        chk("rst_flit", 64'(fout_flit_o), 64'd0);
        chk("rst_route", 64'(fout_route_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_ready", 64'(fin_ready_o), 64'd1);
        fin_vc_i = 2'd3;
        #1 chk("ready_bad_vc", 64'(fin_ready_o), 64'd0);
        fin_vc_i = 2'd0;
        @(posedge clk);
        #1;

        // Single-flit packets: latency 1, route per destination
        for (int i = 0; i < 6; i++) begin
            f = mk(HD, tbl[i].dx, tbl[i].dy, 8'd0, tbl[i].data);
            push(tbl[i].vc, f, tbl[i].exp_route, 1'b1, acc);
            chk("tbl_acc", 64'(acc), 64'd1);
            @(negedge clk);
            chk("tbl_valid", 64'(fout_valid_o), 64'd1);
            chk("tbl_vc", 64'(fout_vc_o), 64'(tbl[i].vc));
            chk("tbl_route", 64'(fout_route_o), 64'(tbl[i].exp_route));
            @(posedge clk);
            #1;
            drain("tbl", 4);
        end

        // Three-flit packet on VC0 with the consumer always ready
        p0 = popped;
        fout_ready_i = 1'b1;
        push(0, mk(HD, 1'b1, 1'b0, 8'd2, 22'h00111), RE, 1'b1, acc);
        push(0, mk(BD, 1'b0, 1'b1, 8'd0, 22'h00222), RE, 1'b1, acc);
        push(0, mk(TL, 1'b0, 1'b0, 8'd0, 22'h00333), RE, 1'b1, acc);
        drain("t2", 8);
        chk("t2_count", 64'(popped - p0), 64'd3);
        chk("t2_err", 64'(err_o), 64'd0);
        push(0, mk(HD, 1'b0, 1'b0, 8'd0, 22'h00444), RL, 1'b1, acc);
        drain("t2_after", 4);

        // Fill VC2 to capacity, fifth flit refused
        for (int i = 0; i < 5; i++) begin
            f = (i == 0) ? mk(HD, 1'b1, 1'b0, 8'd3, 22'h00500) :
                (i == 3) ? mk(TL, 1'b0, 1'b0, 8'd0, 22'h00503) :
                (i == 4) ? mk(HD, 1'b0, 1'b1, 8'd0, 22'h00504) :
                           mk(BD, 1'b0, 1'b0, 8'd0, 22'(32'h500 + i));
            push(2, f, RE, 1'b1, acc);
            chk("t3_acc", 64'(acc), (i < 4) ? 64'd1 : 64'd0);
        end
        fin_vc_i = 2'd0;
        #1 chk("t3_other_vc_ready", 64'(fin_ready_o), 64'd1);
        fin_vc_i = 2'd2;
        fout_ready_i = 1'b1;
        @(negedge clk);
        chk("t3_full_pop_ready", 64'(fin_ready_o), 64'd0);
        @(posedge clk);
        #1;
        drain("t3", 10);

        // VC0 preempts a VC2 packet in flight; VC2 body keeps its latched route
        push(2, mk(HD, 1'b0, 1'b1, 8'd2, 22'h00601), RS, 1'b1, acc);
        push(2, mk(BD, 1'b1, 1'b0, 8'd0, 22'h00602), RS, 1'b1, acc);
        push(2, mk(TL, 1'b0, 1'b0, 8'd0, 22'h00603), RS, 1'b1, acc);
        fout_ready_i = 1'b1;
        @(posedge clk);
        #1 fout_ready_i = 1'b0;
        push(0, mk(HD, 1'b1, 1'b0, 8'd1, 22'h00701), RE, 1'b1, acc);
        push(0, mk(TL, 1'b0, 1'b1, 8'd0, 22'h00702), RE, 1'b1, acc);
        @(negedge clk);
        chk("t4_prio_vc", 64'(fout_vc_o), 64'd0);
        @(posedge clk);
        #1;
        drain("t4", 10);

        // Reset mid-packet discards flits, state and routes
        push(0, mk(HD, 1'b1, 1'b0, 8'd3, 22'h00801), RE, 1'b1, acc);
        push(0, mk(BD, 1'b0, 1'b0, 8'd0, 22'h00802), RE, 1'b1, acc);
        fout_ready_i = 1'b1;
        @(posedge clk);
        #1 fout_ready_i = 1'b0;
        push(0, mk(BD, 1'b0, 1'b0, 8'd0, 22'h00803), RE, 1'b1, acc);
        do_reset();
        @(negedge clk);
        chk("t5_valid", 64'(fout_valid_o), 64'd0);
        chk("t5_ready", 64'(fin_ready_o), 64'd1);
        chk("t5_route", 64'(fout_route_o), 64'd0);
        @(posedge clk);
        #1;
        push(0, mk(BD, 1'b1, 1'b0, 8'd0, 22'h00804), 5'b00000, !ERR_CHK, acc);
        @(negedge clk);
        chk("t5_body_valid", 64'(fout_valid_o), 64'(!ERR_CHK));
        @(posedge clk);
        #1;
        drain("t5", 4);

        // Body on an idle VC: dropped with sticky error when checking, else forwarded
        do_reset();
        push(1, mk(BD, 1'b1, 1'b0, 8'd0, 22'h00901), 5'b00000, !ERR_CHK, acc);
        @(negedge clk);
        chk("t6_valid", 64'(fout_valid_o), 64'(!ERR_CHK));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_err", 64'(err_o), 64'(ERR_CHK));
        @(posedge clk);
        #1;
        drain("t6", 4);
        push(1, mk(HD, 1'b0, 1'b0, 8'd0, 22'h00902), RL, 1'b1, acc);
        drain("t6_head", 4);
        chk("t6_err_sticky", 64'(err_o), 64'(ERR_CHK));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
